// File: rtl/neuron_operand_sequencer.sv
// Operand feeder for the FP multiplier: buffers act/wgt pairs and streams them on start (SEQ_ZERO_SKIP_EN skips +/-0 pairs).
// First pair is valid one cycle after start; a/b/op_index hold while op_valid && !op_ready.
module neuron_operand_sequencer #(
    parameter int exp_width  = 8,
    parameter int mant_width = 24,
    parameter int depth      = 16,
    localparam int total_width = exp_width + mant_width,
    localparam int aw          = $clog2(depth)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [aw-1:0]          wr_addr,
    input  logic [total_width-1:0] wr_data,
    input  logic                   start,
    input  logic [aw:0]            len,
    input  logic [2:0]             round_mode_in,
    output logic                   busy,
    output logic                   done,
    output logic [total_width-1:0] a,
    output logic [total_width-1:0] b,
    output logic [2:0]             round_mode,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic                   op_last,
    output logic [aw-1:0]          op_index,
    input  logic [4:0]             mul_exceptions,
    output logic [4:0]             exc_sticky
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [aw:0] depth_w = (aw + 1)'(depth);

    state_t state, state_nxt;

    logic [total_width-1:0] act [depth];
    logic [total_width-1:0] wgt [depth];

    logic [aw-1:0] idx;
    logic [aw:0]   run_len;
    logic [aw:0]   len_clamped;
    logic          at_last;
    logic          handshake;
    logic          skip;
    logic          advance;

    assign len_clamped = (len > depth_w) ? depth_w : len;
    assign at_last     = ({1'b0, idx} == run_len - 1'b1);

`ifdef SEQ_ZERO_SKIP_EN
    // Exponent and fraction both zero means +/-0, whose product needs no multiplier pass.
    assign skip = (state == RUN) &&
                  ((act[idx][total_width-2:0] == '0) || (wgt[idx][total_width-2:0] == '0));
`else
    assign skip = 1'b0;
`endif

    assign handshake = op_valid && op_ready;
    assign advance   = handshake || skip;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len_clamped == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (advance && at_last) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        op_valid = 1'b0;
        op_last  = 1'b0;
        case (state)
            RUN: begin
                busy     = 1'b1;
                op_valid = !skip;
                op_last  = !skip && at_last;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            run_len    <= '0;
            round_mode <= '0;
            exc_sticky <= '0;
        end else if (state == IDLE && start) begin
            idx        <= '0;
            run_len    <= len_clamped;
            round_mode <= round_mode_in;
            exc_sticky <= '0;
        end else if (state == RUN && advance) begin
            if (handshake) begin
                exc_sticky <= exc_sticky | mul_exceptions;
            end
            if (!at_last) begin
                idx <= idx + 1'b1;
            end
        end
    end

    // Banks are plain storage: no reset, writable only while idle so a run sees a frozen snapshot.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            if (wr_sel) begin
                wgt[wr_addr] <= wr_data;
            end else begin
                act[wr_addr] <= wr_data;
            end
        end
    end

    assign a        = act[idx];
    assign b        = wgt[idx];
    assign op_index = idx;

endmodule

// File: tb/tb_neuron_operand_sequencer.sv
// Directed bench for neuron_operand_sequencer: expected pairs are queued at start and popped on each handshake.
module tb_neuron_operand_sequencer;
    localparam int DEPTH = 16;
    localparam int TW    = 32;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [TW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic [2:0]    round_mode_in = '0;
    logic          busy;
    logic          done;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic [2:0]    round_mode;
    logic          op_valid;
    logic          op_ready = 1'b0;
    logic          op_last;
    logic [AW-1:0] op_index;
    logic [4:0]    mul_exceptions = '0;
    logic [4:0]    exc_sticky;

    neuron_operand_sequencer #(
        .exp_width (8),
        .mant_width(24),
        .depth     (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_en         (wr_en),
        .wr_sel        (wr_sel),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .start         (start),
        .len           (len),
        .round_mode_in (round_mode_in),
        .busy          (busy),
        .done          (done),
        .a             (a),
        .b             (b),
        .round_mode    (round_mode),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_last       (op_last),
        .op_index      (op_index),
        .mul_exceptions(mul_exceptions),
        .exc_sticky    (exc_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic [AW-1:0] index;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [TW-1:0] act_m [DEPTH];
    logic [TW-1:0] wgt_m [DEPTH];
    logic [4:0]    exc_tab [DEPTH];
    logic [4:0]    exp_sticky;
    logic [2:0]    exp_rm;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic bank_write(input logic sel, input int addr, input logic [TW-1:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
        if (sel) wgt_m[addr] = d;
        else     act_m[addr] = d;
    endtask

    // Queues the pairs the run should present, then pulses start for one edge.
    task automatic start_run(input int n, input logic [2:0] rm);
        int l;
        l = (n > DEPTH) ? DEPTH : n;
        exp_sticky = '0;
        for (int i = 0; i < l; i++) begin
            bit sk;
            sk = 1'b0;
`ifdef SEQ_ZERO_SKIP_EN
            sk = (act_m[i][TW-2:0] == '0) || (wgt_m[i][TW-2:0] == '0);
`endif
            if (!sk) begin
                sb.push_back('{act_m[i], wgt_m[i], AW'(i), (i == l - 1)});
                exp_sticky |= exc_tab[i];
            end
        end
        exp_rm        = rm;
        start         = 1'b1;
        len           = (AW + 1)'(n);
        round_mode_in = rm;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Runs cycles until done, checking every presented pair against the queue front.
    task automatic drain(input int budget, input bit toggle, input int exp_busy_cycles);
        int   hs;
        int   last_hs;
        int   busy_cyc;
        bit   seen;
        exp_t e;
        hs = 0; last_hs = -1; busy_cyc = 0; seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            op_ready = toggle ? c[0] : 1'b1;
            @(negedge clk);
            if (c == 0) begin
                check("sticky_clear_on_start", exc_sticky, 5'b0);
                check("round_mode_latched", round_mode, exp_rm);
            end
            mul_exceptions = op_valid ? exc_tab[op_index] : 5'b0;
            if (busy) busy_cyc++;
            if (op_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_op_valid", op_valid, 1'b0);
                end else begin
                    e = sb[0];
                    check("pair_a", a, e.a);
                    check("pair_b", b, e.b);
                    check("pair_index", op_index, e.index);
                    check("pair_last", op_last, e.last);
                    if (op_ready) begin
                        void'(sb.pop_front());
                        hs++;
                        last_hs = c;
                    end
                end
            end
            if (done) begin
                seen = 1'b1;
                check("done_timing", c, last_hs + 1);
                check("pairs_left", sb.size(), 0);
                check("exc_sticky_run", exc_sticky, exp_sticky);
            end
            @(posedge clk); #1;
        end
        op_ready       = 1'b0;
        mul_exceptions = '0;
        check("done_seen", seen, 1'b1);
        @(negedge clk);
        check("done_single_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        if (exp_busy_cycles > 0) check("busy_cycles", busy_cyc, exp_busy_cycles);
        @(posedge clk); #1;
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            act_m[i]   = 'x;
            wgt_m[i]   = 'x;
            exc_tab[i] = '0;
        end

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_op_last", op_last, 1'b0);
        check("rst_op_index", op_index, 4'd0);
        check("rst_round_mode", round_mode, 3'd0);
        check("rst_exc_sticky", exc_sticky, 5'd0);
        @(posedge clk); #1;

        // 1.5 x 1.25 pairs, streamed with ready held high
        for (int i = 0; i < 3; i++) begin
            bank_write(1'b0, i, 32'h3FC0_0000);
            bank_write(1'b1, i, 32'h3FA0_0000);
        end
        start_run(3, 3'b001);
        drain(50, 1'b0, 4);

        // Stalling ready plus exceptions on idx 1 and 2
        exc_tab[1] = 5'b00100;
        exc_tab[2] = 5'b00001;
        start_run(3, 3'b001);
        drain(50, 1'b1, 0);
        check("exc_sticky_held", exc_sticky, 5'b00101);
        exc_tab[1] = '0;
        exc_tab[2] = '0;

        // Zero length: done right after start, sticky cleared
        start_run(0, 3'b010);
        drain(20, 1'b0, 1);

        // Over-long run clamps to the full buffer
        for (int i = 0; i < DEPTH; i++) begin
            bank_write(1'b0, i, 32'h4000_0000 | (i * 32'h1111));
            bank_write(1'b1, i, 32'h3E00_0000 + i);
        end
        start_run(31, 3'b011);
        drain(100, 1'b0, 17);

        // Writes while running must be dropped
        start_run(2, 3'b100);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        wr_sel = 1'b1; wr_addr = 4'd1; wr_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        wr_en = 1'b0;
        drain(50, 1'b0, 0);

        // Write coinciding with start is visible to that run
        act_m[3] = 32'h4049_0FDB;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd3; wr_data = 32'h4049_0FDB;
        start_run(4, 3'b101);
        wr_en = 1'b0;
        drain(50, 1'b0, 5);

        // Asynchronous reset after two handshakes of a five-pair run
        exc_tab[0] = 5'b10000;
        start_run(5, 3'b110);
        for (int c = 0; c < 2; c++) begin
            op_ready = 1'b1;
            @(negedge clk);
            mul_exceptions = exc_tab[op_index];
            check("prerst_op_valid", op_valid, 1'b1);
            check("prerst_op_index", op_index, c);
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_op_valid", op_valid, 1'b0);
        check("midrst_op_last", op_last, 1'b0);
        check("midrst_op_index", op_index, 4'd0);
        check("midrst_round_mode", round_mode, 3'd0);
        check("midrst_exc_sticky", exc_sticky, 5'd0);
        @(negedge clk);
        rst_n          = 1'b1;
        op_ready       = 1'b0;
        mul_exceptions = '0;
        sb.delete();
        exc_tab[0] = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("postrst_no_done", done, 1'b0);
            check("postrst_idle", busy, 1'b0);
        end
        @(posedge clk); #1;

`ifdef SEQ_ZERO_SKIP_EN
        // act[1] = +0 is skipped: handshakes on idx 0 and 2, three RUN cycles plus DONE
        bank_write(1'b0, 1, 32'h0000_0000);
        start_run(3, 3'b000);
        drain(50, 1'b0, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
